chunked_rca_adder: RTL

//   Parametrised multi-cycle add/subtract unit; next generation of the 4-bit registered RCA.

---
 rtl/chunked_rca_adder.sv | 102 ++++++++++
 1 files changed

// File: rtl/chunked_rca_adder.sv
// Multi-cycle add/subtract unit: one CHUNK-bit ripple slice reused
// NCHUNK times, with the inter-slice carry held in a flop.
module chunked_rca_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   Q,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_nx;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] sa;
  logic [CHUNK-1:0] sb;
  logic [CHUNK-1:0] ss;
  logic [CHUNK:0]   c;
  logic             last;

  assign last = (idx == IW'(NCHUNK - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // c[CHUNK-1] is the carry into the slice MSB, used for overflow
  always_comb begin
    sa     = a_r[int'(idx)*CHUNK +: CHUNK];
    sb     = b_r[int'(idx)*CHUNK +: CHUNK];
    ss     = '0;
    c      = '0;
    c[0]   = carry;
    for (int i = 0; i < CHUNK; i++) begin
      ss[i]   = sa[i] ^ sb[i] ^ c[i];
      c[i+1]  = (sa[i] & sb[i]) | (c[i] & (sa[i] ^ sb[i]));
    end
    sum_nx = sum_r;
    sum_nx[int'(idx)*CHUNK +: CHUNK] = ss;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      idx   <= '0;
      Q     <= '0;
      ovf   <= 1'b0;
    end else if (enable) begin
      state <= state_nx;
      if (state != RUN && start) begin
        a_r   <= A;
        b_r   <= sub ? ~B : B;
        carry <= sub ? 1'b1 : Cin;
        idx   <= '0;
      end else if (state == RUN) begin
        carry <= c[CHUNK];
        sum_r <= sum_nx;
        idx   <= last ? '0 : idx + 1'b1;
        if (last) begin
          Q   <= {c[CHUNK], sum_nx};
          ovf <= c[CHUNK] ^ c[CHUNK-1];
        end
      end
    end
  end

endmodule
